// File: rtl/cmp_offset_cal_sar.sv
// SAR search for comparator offset trim codes: one shared DAC, enabled channels visited
// lowest first, each bit decided by a majority vote after a settle delay.
module cmp_offset_cal_sar #(
   parameter int N_CH       = 8,
   parameter int DAC_BITS   = 16,
   parameter int SETTLE_CYC = 1,
   parameter int VOTES      = 3,
   parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [N_CH-1:0]     ch_en,
   input  logic [N_CH-1:0]     cmp_out,
   output logic [CH_W-1:0]     ch_sel,
   output logic [DAC_BITS-1:0] DAC_ctl,
   output logic                busy,
   output logic                done,
   output logic                result_valid,
   output logic [CH_W-1:0]     result_ch,
   output logic [DAC_BITS-1:0] result_code,
   input  logic [CH_W-1:0]     rd_ch,
   output logic [DAC_BITS-1:0] rd_code
);

   localparam int OW = $clog2(VOTES + 1);
   localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int BW = $clog2(DAC_BITS);

   localparam logic [OW-1:0]       HALF        = OW'(VOTES / 2);
   localparam logic [VW-1:0]       VOTE_LAST   = VW'(VOTES - 1);
   localparam logic [SW-1:0]       SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [BW-1:0]       BIT_TOP     = BW'(DAC_BITS - 1);
   localparam logic [DAC_BITS-1:0] MSB_ONLY    = {1'b1, {(DAC_BITS-1){1'b0}}};
   localparam logic [CH_W:0]       N_CH_L      = (CH_W+1)'(N_CH);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SETTLE, S_SAMPLE, S_DECIDE, S_STORE, S_DONE
   } state_t;

   // With no settle time a DAC update goes straight to sampling.
   localparam state_t S_AFTER_DAC = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;

   state_t                state_reg, state_next;
   logic [N_CH-1:0]       en_reg, en_next;
   logic [CH_W-1:0]       ch_sel_reg, ch_sel_next;
   logic [DAC_BITS-1:0]   dac_reg, dac_next;
   logic [BW-1:0]         bit_reg, bit_next;
   logic [SW-1:0]         settle_reg, settle_next;
   logic [VW-1:0]         vote_reg, vote_next;
   logic [OW-1:0]         ones_reg, ones_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;
   logic                  rv_reg, rv_next;
   logic [CH_W-1:0]       rch_reg, rch_next;
   logic [DAC_BITS-1:0]   rcode_reg, rcode_next;
   logic                  mem_we;
   logic [N_CH-1:0]       wr_hit;
   logic [DAC_BITS-1:0]   mem_reg [N_CH];

   logic [CH_W-1:0]       first_ch, next_ch;
   logic                  has_next;

   // Lowest enabled channel, and lowest enabled channel above the current one.
   always_comb begin
      first_ch = '0;
      next_ch  = '0;
      has_next = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (en_reg[i]) begin
            first_ch = CH_W'(i);
         end
         if (en_reg[i] && (CH_W'(i) > ch_sel_reg)) begin
            next_ch  = CH_W'(i);
            has_next = 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      en_next     = en_reg;
      ch_sel_next = ch_sel_reg;
      dac_next    = dac_reg;
      bit_next    = bit_reg;
      settle_next = settle_reg;
      vote_next   = vote_reg;
      ones_next   = ones_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      rv_next     = 1'b0;
      rch_next    = rch_reg;
      rcode_next  = rcode_reg;
      mem_we      = 1'b0;

      if (abort) begin
         state_next  = S_IDLE;
         dac_next    = '0;
         ones_next   = '0;
         vote_next   = '0;
         settle_next = '0;
         busy_next   = 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  en_next    = ch_en;
                  busy_next  = 1'b1;
                  state_next = (ch_en == '0) ? S_DONE : S_SETUP;
               end
            end
            S_SETUP: begin
               ch_sel_next = first_ch;
               dac_next    = MSB_ONLY;
               bit_next    = BIT_TOP;
               settle_next = '0;
               vote_next   = '0;
               ones_next   = '0;
               state_next  = S_AFTER_DAC;
            end
            S_SETTLE: begin
               if (settle_reg == SETTLE_LAST) begin
                  settle_next = '0;
                  state_next  = S_SAMPLE;
               end else begin
                  settle_next = settle_reg + SW'(1);
               end
            end
            S_SAMPLE: begin
               ones_next = ones_reg + OW'(cmp_out[ch_sel_reg]);
               if (vote_reg == VOTE_LAST) begin
                  vote_next  = '0;
                  state_next = S_DECIDE;
               end else begin
                  vote_next = vote_reg + VW'(1);
               end
            end
            S_DECIDE: begin
               // Majority says the DAC is above threshold: this bit must be dropped.
               if (ones_reg > HALF) begin
                  dac_next[bit_reg] = 1'b0;
               end
               ones_next = '0;
               if (bit_reg == '0) begin
                  state_next = S_STORE;
               end else begin
                  dac_next[bit_reg - BW'(1)] = 1'b1;
                  bit_next   = bit_reg - BW'(1);
                  state_next = S_AFTER_DAC;
               end
            end
            S_STORE: begin
               mem_we     = 1'b1;
               rv_next    = 1'b1;
               rch_next   = ch_sel_reg;
               rcode_next = dac_reg;
               if (has_next) begin
                  ch_sel_next = next_ch;
                  dac_next    = MSB_ONLY;
                  bit_next    = BIT_TOP;
                  state_next  = S_AFTER_DAC;
               end else begin
                  state_next = S_DONE;
               end
            end
            S_DONE: begin
               done_next  = 1'b1;
               dac_next   = '0;
               busy_next  = 1'b0;
               state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         en_reg     <= '0;
         ch_sel_reg <= '0;
         dac_reg    <= '0;
         bit_reg    <= '0;
         settle_reg <= '0;
         vote_reg   <= '0;
         ones_reg   <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         rv_reg     <= 1'b0;
         rch_reg    <= '0;
         rcode_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         en_reg     <= en_next;
         ch_sel_reg <= ch_sel_next;
         dac_reg    <= dac_next;
         bit_reg    <= bit_next;
         settle_reg <= settle_next;
         vote_reg   <= vote_next;
         ones_reg   <= ones_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         rv_reg     <= rv_next;
         rch_reg    <= rch_next;
         rcode_reg  <= rcode_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_hit
         assign wr_hit[gi] = mem_we && (ch_sel_reg == CH_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (wr_hit[i]) begin
               mem_reg[i] <= dac_reg;
            end
         end
      end
   end

   assign rd_code      = ({1'b0, rd_ch} < N_CH_L) ? mem_reg[rd_ch] : '0;
   assign ch_sel       = ch_sel_reg;
   assign DAC_ctl      = dac_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign result_valid = rv_reg;
   assign result_ch    = rch_reg;
   assign result_code  = rcode_reg;

endmodule

// File: tb/tb_cmp_offset_cal_sar.sv
// Randomised bench for cmp_offset_cal_sar: comparators modelled as DAC > threshold (with
// optional single-sample noise per bit window), results checked against a timing/value model.
module tb_cmp_offset_cal_sar;

   localparam int N   = 3;
   localparam int B   = 4;
   localparam int S   = 1;
   localparam int V   = 3;
   localparam int CW  = 2;
   localparam int PER = B * (S + V + 1) + 1;

   logic          clk = 1'b0;
   logic          rst_n, start, abort;
   logic [N-1:0]  ch_en, cmp_out;
   logic [CW-1:0] ch_sel, result_ch, rd_ch;
   logic [B-1:0]  dac, result_code, rd_code;
   logic          busy, done, result_valid;

   int total = 0;
   int bad   = 0;
   int thr[N];
   int exp_mem[N];
   bit noise;

   always #5 clk = ~clk;

   cmp_offset_cal_sar #(
      .N_CH(N), .DAC_BITS(B), .SETTLE_CYC(S), .VOTES(V), .CH_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_en(ch_en),
      .cmp_out(cmp_out), .ch_sel(ch_sel), .DAC_ctl(dac), .busy(busy), .done(done),
      .result_valid(result_valid), .result_ch(result_ch), .result_code(result_code),
      .rd_ch(rd_ch), .rd_code(rd_code)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic check_regs();
      for (int c = 0; c < 4; c++) begin
         rd_ch = CW'(c);
         #1;
         chk($sformatf("rd_code[%0d]", c), rd_code, (c < N) ? exp_mem[c] : 0);
      end
   endtask

   // One calibration run; abort_cyc < 0 means no abort. Cycle index = edges after the start edge.
   task automatic run(input logic [N-1:0] en, input int abort_cyc, input bit hold);
      int order[$];
      int e, done_cyc, last, since, off;
      bit ab, exp_rv;
      int kk;
      logic [B-1:0] prev;
      order = {};
      for (int c = 0; c < N; c++) if (en[c]) order.push_back(c);
      e = order.size();
      done_cyc = (e == 0) ? 1 : 2 + e * PER;
      last = done_cyc + 2;
      if (abort_cyc >= 0 && abort_cyc + 3 < last) last = abort_cyc + 3;
      $display("run en=%b channels=%0d noise=%0d abort_cyc=%0d thr=%0d,%0d,%0d",
               en, e, noise, abort_cyc, thr[0], thr[1], thr[2]);
      @(negedge clk);
      ch_en = en;
      start = 1'b1;
      @(posedge clk);
      prev  = 'x;
      since = 0;
      off   = 0;
      for (int cyc = 0; cyc <= last; cyc++) begin
         @(negedge clk);
         if (!(hold && cyc == 0)) start = 1'b0;
         ab     = (abort_cyc >= 0) && (cyc > abort_cyc);
         abort  = (cyc == abort_cyc);
         exp_rv = 1'b0;
         kk     = 0;
         for (int k = 0; k < e; k++) begin
            if (!ab && cyc == 1 + (k + 1) * PER) begin
               exp_rv = 1'b1;
               kk     = k;
            end
         end
         chk("result_valid", result_valid, exp_rv);
         if (exp_rv) begin
            chk("result_ch", result_ch, order[kk]);
            chk("result_code", result_code, thr[order[kk]]);
            exp_mem[order[kk]] = thr[order[kk]];
         end
         chk("done", done, (cyc == done_cyc) && !ab);
         chk("busy", busy, (cyc < done_cyc) && !ab);
         if (ab || cyc >= done_cyc) chk("dac_idle", dac, 0);
         // At most one inverted sample while the DAC word is held constant.
         if (dac !== prev) begin
            prev  = dac;
            since = 0;
            off   = $urandom_range(0, 4);
         end else begin
            since++;
         end
         for (int c = 0; c < N; c++) begin
            cmp_out[c] = (int'(dac) > thr[c]) ^ (noise && since == off && ch_sel == CW'(c));
         end
      end
      abort = 1'b0;
      check_regs();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ch_en = '0; cmp_out = '0; rd_ch = '0;
      noise = 1'b0;
      for (int c = 0; c < N; c++) exp_mem[c] = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_dac", dac, 0);
      chk("rst_ch_sel", ch_sel, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_rcode", result_code, 0);
      rst_n = 1'b1;
      check_regs();

      thr[0] = 5; thr[1] = 12; thr[2] = 3;
      run(3'b010, -1, 1'b0);
      run(3'b011, -1, 1'b0);
      noise = 1'b1; thr[0] = 9;
      run(3'b001, -1, 1'b0);
      noise = 1'b0; thr[0] = 2; thr[1] = 10;
      run(3'b011, 25, 1'b0);
      run(3'b000, -1, 1'b1);
      run(3'b111, -1, 1'b0);

      for (int t = 0; t < 10; t++) begin
         logic [N-1:0] en;
         int ne, ac;
         en = N'($urandom_range(0, 7));
         ne = $countones(en);
         for (int c = 0; c < N; c++) thr[c] = $urandom_range(0, 15);
         noise = 1'($urandom_range(0, 1));
         ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 + ne * PER)) : -1;
         run(en, ac, 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      ch_en = 3'b111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_dac", dac, 0);
      chk("arst_ch_sel", ch_sel, 0);
      chk("arst_rcode", result_code, 0);
      for (int c = 0; c < N; c++) exp_mem[c] = 0;
      check_regs();
      @(negedge clk);
      rst_n = 1'b1;
      noise = 1'b0; thr[0] = 15; thr[1] = 0; thr[2] = 8;
      run(3'b101, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
